// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants for the MEM stage: ctrl bit map, access sizes, FSM states
package mem_stage_pkg;

  // Reset PC presented on the WB bundle
  localparam logic [31:0] PC_RST_DEF = 32'h1c000000;

  // Bit positions inside ctrl_in
  localparam int C_LD    = 0;
  localparam int C_ST    = 1;
  localparam int C_SZ    = 2;  // two bits: [C_SZ+1:C_SZ]
  localparam int C_LDU   = 4;
  localparam int C_RW    = 5;
  localparam int C_MULHI = 6;
  localparam int C_VALID = 7;

  // Access size encodings; 2'b11 behaves as a word
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Cache handshake FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane strobes, store replication and load extract/extend
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then size-dependent strobes, replication and extension
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_B: begin
        o_wstrb   = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_st_data[7:0]}};
        o_ld_data = i_ld_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_wstrb   = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata   = {2{i_st_data[15:0]}};
        o_ld_data = i_ld_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_wstrb   = 4'hF;
        o_wdata   = i_st_data;
        o_ld_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: multiply finish, DCache handshake, MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          WORD    = 32,
  parameter int          REG_LOG = 5,
  parameter logic [31:0] PC_RST  = PC_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          inst_in,
  input  logic [7:0]           ctrl_in,
  input  logic                 cal_sel_in,
  input  logic [WORD-1:0]      alu_res_in,
  input  logic [3*REG_LOG-1:0] rs_in,
  input  logic                 sign_in,
  input  logic [3*WORD-1:0]    mul_tmp_in,
  input  logic [WORD-1:0]      st_data_in,
  output logic                 dc_req,
  output logic                 dc_we,
  output logic [WORD-1:0]      dc_addr,
  output logic [3:0]           dc_wstrb,
  output logic [WORD-1:0]      dc_wdata,
  input  logic                 dc_addr_ok,
  input  logic                 dc_data_ok,
  input  logic [WORD-1:0]      dc_rdata,
  output logic                 stall_out,
  output logic                 wb_valid,
  output logic [31:0]          wb_pc,
  output logic                 wb_we,
  output logic [REG_LOG-1:0]   wb_rd,
  output logic [WORD-1:0]      wb_data,
  output logic                 wb_ale
);

  state_e            r_state;
  state_e            w_next;
  logic              w_ld, w_st, w_valid, w_mis, w_mem_op, w_done;
  logic [1:0]        w_size;
  logic [2*WORD-1:0] w_mid_ext, w_prod;
  logic [WORD-1:0]   w_mres, w_res, w_ld_data, w_wdata;
  logic [3:0]        w_wstrb;
  logic              w_unused;

  assign w_unused = ^{inst_in, rs_in[2*REG_LOG-1:0]};

  assign w_ld    = ctrl_in[C_LD];
  assign w_st    = ctrl_in[C_ST];
  assign w_valid = ctrl_in[C_VALID];
  assign w_size  = ctrl_in[C_SZ+1:C_SZ];

  // Alignment check and memory-op qualification
  always_comb begin
    w_mis    = ((w_size == SZ_H) && alu_res_in[0]) || (w_size[1] && (alu_res_in[1:0] != 2'b00));
    w_mem_op = w_valid && (w_ld || w_st) && !w_mis;
  end

  // Final multiply accumulation: {hi,lo} plus the middle partial product shifted by 16
  always_comb begin
    w_mid_ext = sign_in ? {{WORD{mul_tmp_in[2*WORD-1]}}, mul_tmp_in[2*WORD-1:WORD]}
                        : {{WORD{1'b0}}, mul_tmp_in[2*WORD-1:WORD]};
    w_prod    = {mul_tmp_in[3*WORD-1:2*WORD], mul_tmp_in[WORD-1:0]} + (w_mid_ext << 16);
    w_mres    = ctrl_in[C_MULHI] ? w_prod[2*WORD-1:WORD] : w_prod[WORD-1:0];
    w_res     = cal_sel_in ? w_mres : alu_res_in;
  end

  mem_lane_align u_align (
    .i_addr_lo     (alu_res_in[1:0]),
    .i_size        (w_size),
    .i_ld_unsigned (ctrl_in[C_LDU]),
    .i_st_data     (st_data_in),
    .i_rdata       (dc_rdata),
    .o_wstrb       (w_wstrb),
    .o_wdata       (w_wdata),
    .o_ld_data     (w_ld_data)
  );

  // Handshake decode: request/stall/completion and next state; quiet while in reset
  always_comb begin
    dc_req    = 1'b0;
    stall_out = 1'b0;
    w_done    = 1'b0;
    w_next    = r_state;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op) begin
            dc_req = 1'b1;
            if (dc_addr_ok && dc_data_ok) begin
              w_done = 1'b1;
            end else begin
              stall_out = 1'b1;
              if (dc_addr_ok) w_next = ST_WAIT;
            end
          end else begin
            w_done = 1'b1;
          end
        end
        default: begin
          if (dc_data_ok) begin
            w_done = 1'b1;
            w_next = ST_IDLE;
          end else begin
            stall_out = 1'b1;
          end
        end
      endcase
    end
  end

  // Cache request payload, zero whenever no request is being made
  always_comb begin
    dc_we    = dc_req && w_st;
    dc_addr  = dc_req ? alu_res_in : '0;
    dc_wstrb = dc_we ? w_wstrb : 4'h0;
    dc_wdata = dc_we ? w_wdata : '0;
  end

  // FSM state and MEM/WB register: capture on completion, bubble while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      wb_valid <= 1'b0;
      wb_pc    <= PC_RST;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_ale   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_done) begin
        wb_valid <= w_valid;
        wb_pc    <= pc_in;
        wb_rd    <= rs_in[3*REG_LOG-1:2*REG_LOG];
        wb_we    <= w_mem_op ? (w_ld && !w_st && ctrl_in[C_RW])
                             : (w_valid && ctrl_in[C_RW] && !w_mis);
        wb_data  <= (w_mem_op && w_ld) ? w_ld_data : w_res;
        wb_ale   <= w_valid && w_mis && (w_ld || w_st);
      end else begin
        wb_valid <= 1'b0;
        wb_we    <= 1'b0;
        wb_ale   <= 1'b0;
      end
    end
  end

endmodule
